clock_display_driver: RTL and testbench

Consumes the binary hours/minutes/seconds produced by the clock counter and drives the board's 8-digit multiplexed 7-segment display. Time shows as HH.MM.SS on the low six digits; the top two digits stay dark. Inputs are frame-snapshotted so the display never tears. In edit mode the selected field blinks.

---
 rtl/clock_display_pkg.sv | 32 +++
 rtl/seg7_encoder.sv | 22 ++
 rtl/clock_display_driver.sv | 152 +++++++++++++++
 tb/tb_clock_display_driver.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared types and constants for the HH.MM.SS multiplexed 7-segment display driver.
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package clock_display_pkg;

  typedef enum logic [1:0] {
    FIELD_SEC  = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_HOUR = 2'd2,
    FIELD_NONE = 2'd3
  } field_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // Values above 59 are passed through unclamped, so 63 becomes tens=6, ones=3.
  function automatic bcd_t to_bcd(input logic [5:0] v);
    bcd_t r;
    r.tens = 4'(v / 6'd10);
    r.ones = 4'(v % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD to active-low 7-segment encoder with blanking and decimal point.
// Blanking only darkens segments a-g; the dp request is honoured independently.
module seg7_encoder
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] cathodes
);

  logic [7:0] code;
  logic [6:0] seg;

  always_comb begin
    code = SEG_BLANK;
    if (bcd <= 4'd9) code = SEG_DIGIT[bcd];
    seg = blank ? SEG_BLANK[6:0] : code[6:0];
    cathodes = {~dp, seg};
  end

endmodule

// File: rtl/clock_display_driver.sv
// Scans HH.MM.SS across the low six digits of an 8-digit multiplexed display,
// snapshotting the time once per frame and blinking the field under edit.
module clock_display_driver
  import clock_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_i,
  input  logic [5:0] seconds_i,
  input  logic [5:0] minutes_i,
  input  logic [4:0] hours_i,
  input  logic       edit_i,
  input  logic [1:0] edit_field_i,
  output logic [7:0] an_o,
  output logic [7:0] dec_cathodes_o
);

  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [REF_W-1:0] refresh_cnt;
  logic             tick;
  // slot_idx is the digit that the next tick puts on the display.
  logic [IDX_W-1:0] slot_idx;
  logic             frame_start;

  logic [5:0] snap_sec;
  logic [5:0] snap_min;
  logic [4:0] snap_hour;

  logic [BLK_W-1:0] blink_cnt;
  logic [BLK_W-1:0] blink_cnt_nxt;
  logic             blink_phase;
  logic             blink_phase_nxt;
  field_t           field_q;
  field_t           field_cur;

  logic [5:0] sec_v;
  logic [5:0] min_v;
  logic [4:0] hour_v;
  bcd_t       sec_bcd;
  bcd_t       min_bcd;
  bcd_t       hour_bcd;

  logic [3:0] digit_bcd;
  field_t     digit_field;
  logic       digit_on;
  logic       digit_dp;
  logic       digit_blank;
  logic [7:0] enc_cathodes;
  logic [7:0] an_nxt;
  logic [7:0] cath_nxt;

  assign tick        = (refresh_cnt == REF_LAST);
  assign frame_start = tick && (slot_idx == '0);
  assign field_cur   = field_t'(edit_field_i);

  // Blink phase: restart visible on edit exit or any field change.
  always_comb begin
    blink_cnt_nxt   = blink_cnt + 1'b1;
    blink_phase_nxt = blink_phase;
    if (!edit_i || (field_cur != field_q)) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b1;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end
  end

  // Digit 0 of a frame reads the live inputs, the rest read the snapshot.
  always_comb begin
    sec_v    = frame_start ? seconds_i : snap_sec;
    min_v    = frame_start ? minutes_i : snap_min;
    hour_v   = frame_start ? hours_i   : snap_hour;
    sec_bcd  = to_bcd(sec_v);
    min_bcd  = to_bcd(min_v);
    hour_bcd = to_bcd({1'b0, hour_v});
  end

  always_comb begin
    digit_bcd   = 4'd0;
    digit_field = FIELD_NONE;
    digit_on    = 1'b1;
    digit_dp    = 1'b0;
    case (slot_idx)
      3'd0: begin digit_bcd = sec_bcd.ones;  digit_field = FIELD_SEC;  end
      3'd1: begin digit_bcd = sec_bcd.tens;  digit_field = FIELD_SEC;  end
      3'd2: begin digit_bcd = min_bcd.ones;  digit_field = FIELD_MIN;  digit_dp = 1'b1; end
      3'd3: begin digit_bcd = min_bcd.tens;  digit_field = FIELD_MIN;  end
      3'd4: begin digit_bcd = hour_bcd.ones; digit_field = FIELD_HOUR; digit_dp = 1'b1; end
      3'd5: begin digit_bcd = hour_bcd.tens; digit_field = FIELD_HOUR; end
      default: digit_on = 1'b0;
    endcase
  end

  assign digit_blank = edit_i && (field_cur != FIELD_NONE) && !blink_phase_nxt &&
                       digit_on && (digit_field == field_cur);

  seg7_encoder u_seg7_encoder (
    .bcd      (digit_bcd),
    .blank    (digit_blank),
    .dp       (digit_dp),
    .cathodes (enc_cathodes)
  );

  always_comb begin
    an_nxt   = 8'hFF;
    cath_nxt = SEG_BLANK;
    if (digit_on) begin
      an_nxt   = ~(8'h01 << slot_idx);
      cath_nxt = enc_cathodes;
    end
  end

  // Registered scan state and outputs; outputs update one clock after each tick.
  always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      refresh_cnt    <= '0;
      slot_idx       <= '0;
      snap_sec       <= '0;
      snap_min       <= '0;
      snap_hour      <= '0;
      blink_cnt      <= '0;
      blink_phase    <= 1'b1;
      field_q        <= FIELD_NONE;
      an_o           <= 8'hFF;
      dec_cathodes_o <= SEG_BLANK;
    end else begin
      refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      field_q     <= field_cur;
      if (frame_start) begin
        snap_sec  <= seconds_i;
        snap_min  <= minutes_i;
        snap_hour <= hours_i;
      end
      if (tick) begin
        slot_idx       <= slot_idx + 1'b1;
        an_o           <= an_nxt;
        dec_cathodes_o <= cath_nxt;
      end
    end
  end

endmodule

// File: tb/tb_clock_display_driver.sv
// Scoreboard bench for clock_display_driver with REFRESH_DIV=4, BLINK_DIV=16.
// Expected anode/cathode pairs are queued per digit slot and compared after each tick.
module tb_clock_display_driver;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 16;

  logic       clk_100MHz_i = 1'b0;
  logic       reset_i;
  logic [5:0] seconds_i;
  logic [5:0] minutes_i;
  logic [4:0] hours_i;
  logic       edit_i;
  logic [1:0] edit_field_i;
  logic [7:0] an_o;
  logic [7:0] dec_cathodes_o;

  typedef struct {
    string      tag;
    logic [7:0] an;
    logic [7:0] cath;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  clock_display_driver #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk_100MHz_i   (clk_100MHz_i),
    .reset_i        (reset_i),
    .seconds_i      (seconds_i),
    .minutes_i      (minutes_i),
    .hours_i        (hours_i),
    .edit_i         (edit_i),
    .edit_field_i   (edit_field_i),
    .an_o           (an_o),
    .dec_cathodes_o (dec_cathodes_o)
  );

  always #5 clk_100MHz_i = ~clk_100MHz_i;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Queue n slots starting at digit 'first'; cathodes are packed left to right in c.
  task automatic push_seq(input string tag, input int first, input int n, input logic [63:0] c);
    exp_t e;
    int   idx;
    for (int k = 0; k < n; k++) begin
      idx    = (first + k) % 8;
      e.tag  = $sformatf("%s.d%0d", tag, idx);
      e.an   = (idx < 6) ? ~(8'h01 << idx) : 8'hFF;
      e.cath = c[63 - 8*k -: 8];
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input int first_edges);
    exp_t e;
    int   edges;
    edges = first_edges;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      repeat (edges) @(posedge clk_100MHz_i);
      @(negedge clk_100MHz_i);
      check({e.tag, ".an"}, an_o, e.an);
      check({e.tag, ".seg"}, dec_cathodes_o, e.cath);
      edges = 4;
    end
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hours_i   = h;
    minutes_i = m;
    seconds_i = s;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i      = 1'b0;
    edit_i       = 1'b0;
    edit_field_i = 2'd3;
    set_time(5'd0, 6'd0, 6'd0);
    repeat (3) @(posedge clk_100MHz_i);
    @(negedge clk_100MHz_i);
    check("rst.an", an_o, 8'hFF);
    check("rst.seg", dec_cathodes_o, 8'hFF);

    // Release: nothing lit before the first tick, then digit 0 of 00:00:00.
    reset_i = 1'b1;
    repeat (3) @(posedge clk_100MHz_i);
    @(negedge clk_100MHz_i);
    check("pretick.an", an_o, 8'hFF);
    check("pretick.seg", dec_cathodes_o, 8'hFF);
    @(posedge clk_100MHz_i);
    @(negedge clk_100MHz_i);
    check("first.an", an_o, 8'hFE);
    check("first.seg", dec_cathodes_o, 8'hC0);
    push_seq("zero", 1, 7, 64'hC040_C040_C0FF_FF00);
    drain(4);

    // Full frame 23:59:58.
    set_time(5'd23, 6'd59, 6'd58);
    push_seq("full", 0, 8, 64'h8092_1092_30A4_FFFF);
    drain(4);

    // Anti-tearing: inputs change while digit 3 is shown.
    set_time(5'd12, 6'd34, 6'd56);
    push_seq("tear", 0, 4, 64'h8292_19B0_0000_0000);
    drain(4);
    set_time(5'd12, 6'd35, 6'd0);
    push_seq("tear", 4, 4, 64'h24F9_FFFF_0000_0000);
    drain(4);
    push_seq("tear2", 0, 8, 64'hC0C0_12B0_24F9_FFFF);
    drain(4);

    // Blink on minutes, edit enabled just after digit 3 is shown.
    set_time(5'd12, 6'd34, 6'd56);
    push_seq("pre", 0, 8, 64'h8292_19B0_24F9_FFFF);
    push_seq("pre", 0, 4, 64'h8292_19B0_0000_0000);
    drain(4);
    edit_i       = 1'b1;
    edit_field_i = 2'd1;
    push_seq("blk1a", 4, 4, 64'h24F9_FFFF_0000_0000);
    push_seq("blk0", 0, 4, 64'h8292_7FFF_0000_0000);
    push_seq("blk1b", 4, 4, 64'h24F9_FFFF_0000_0000);
    drain(4);

    // One-cycle edit drop restarts the blink so digits 0-3 land in the visible phase.
    edit_i = 1'b0;
    push_seq("blk1c", 0, 8, 64'h8292_19B0_24F9_FFFF);
    @(posedge clk_100MHz_i);
    @(negedge clk_100MHz_i);
    edit_i = 1'b1;
    drain(3);

    // Field change 1->2 during phase 0 makes hours visible immediately.
    push_seq("fld", 0, 4, 64'h8292_19B0_0000_0000);
    drain(4);
    edit_field_i = 2'd2;
    push_seq("fld", 4, 4, 64'h24F9_FFFF_0000_0000);
    push_seq("fld", 0, 4, 64'h8292_19B0_0000_0000);
    drain(4);

    // Leave edit mode during phase 0: whole display visible.
    edit_i = 1'b0;
    push_seq("exit", 4, 4, 64'h24F9_FFFF_0000_0000);
    push_seq("exit", 0, 4, 64'h8292_19B0_0000_0000);
    drain(4);

    // Mid-frame reset right after digit 3 is shown.
    push_seq("mid", 4, 4, 64'h24F9_FFFF_0000_0000);
    push_seq("mid", 0, 4, 64'h8292_19B0_0000_0000);
    drain(4);
    reset_i = 1'b0;
    #1;
    check("midrst.an", an_o, 8'hFF);
    check("midrst.seg", dec_cathodes_o, 8'hFF);
    repeat (2) @(posedge clk_100MHz_i);
    @(negedge clk_100MHz_i);
    reset_i = 1'b1;
    repeat (3) @(posedge clk_100MHz_i);
    @(negedge clk_100MHz_i);
    check("midrel.an", an_o, 8'hFF);
    check("midrel.seg", dec_cathodes_o, 8'hFF);
    repeat (2) @(posedge clk_100MHz_i);
    @(negedge clk_100MHz_i);
    check("midfirst.an", an_o, 8'hFE);
    check("midfirst.seg", dec_cathodes_o, 8'h82);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
